main_mem_arbiter: RTL and testbench
===================================

# main_mem_arbiter

Two-requester arbiter that shares the single main memory between the core's data port (requester 0) and a second bus master such as a DMA or loader engine (requester 1). It sits between the requesters and `main_mem` in the top level. It issues at most one access per cycle, selects the winner round-robin with an optional bounded lock for bursts, and routes read data back to the requester that issued the read.

## Interface
- `MAX_LOCK`, default 8: maximum consecutive locked grants to one requester while the other is requesting.
- `clk` in 1: system clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `m0_req` in 1: requester 0 access request; level, held until granted.
- `m0_we` in 1: 1 = write, 0 = read.
- `m0_adr` in 16: word address.
- `m0_wdat` in 16: write data.
- `m0_lock` in 1: requester 0 asks to keep ownership after this grant.
- `m0_gnt` out 1: access issued this cycle.
- `m0_rvalid` out 1: read data valid on `m0_rdat`.
- `m0_rdat` out 16: read data.
- `m1_req`, `m1_we`, `m1_adr`, `m1_wdat`, `m1_lock`, `m1_gnt`, `m1_rvalid`, `m1_rdat`: same as above for requester 1.
- `main_mem_read_adr` out 16: memory read address.
- `main_mem_dat` in 16: memory read data, valid the cycle after the address is issued.
- `main_mem_write` out 1: memory write enable.
- `main_mem_write_adr` out 16: memory write address.
- `main_mem_write_dat` out 16: memory write data.

## Operation
- State registers:
  - `last`: last granted requester, reset value 1, so requester 0 wins first.
  - `lock_cnt`: count of consecutive locked grants, width clog2(MAX_LOCK+1), reset value 0.
  - `lock_own`: 1 when the previous grant had lock set, reset value 0.
  - `rd_pend` and `rd_tag`: a read is outstanding, and which requester issued it; reset values 0.
- Winner selection, combinational each cycle:
  - No request: no grant.
  - One request: that requester wins.
  - Both requesting, with owner `o` = `last`:
    - If `lock_own` = 1 and `lock_cnt` < MAX_LOCK, `o` wins.
    - Otherwise the requester other than `last` wins (round-robin).
- Issue:
  - Assert the winner's `mX_gnt`.
  - Drive `main_mem_read_adr` and `main_mem_write_adr` from the winner's address.
  - Drive `main_mem_write_dat` from the winner's write data.
  - Set `main_mem_write` = winner's `we`.
  - With no grant, all address/data outputs are 0 and `main_mem_write` = 0.
- Register update on a grant:
  - `last` ← winner.
  - `lock_own` ← winner's lock.
  - `lock_cnt`:
    - Winner == `last`, `lock_own` was 1, and the other requester is requesting: `lock_cnt` + 1, saturating at MAX_LOCK.
    - Otherwise: 0.
  - No grant: `lock_own` ← 0 and `lock_cnt` ← 0; `last` holds.
- Read return:
  - A granted read sets `rd_pend` = 1 and `rd_tag` = winner for the next cycle.
  - In that next cycle, `m{rd_tag}_rvalid` = 1 and `m{rd_tag}_rdat` = `main_mem_dat`.
  - The other requester's rdat is 0.
  - `rd_pend` clears unless a new read is granted.
  - Back-to-back reads are supported, one return per cycle.
- A write gives no response beyond `gnt`. The write commits on the grant cycle's edge.
- Requesters must hold `we`, `adr`, `wdat` and `lock` stable while `req` = 1 and `gnt` = 0.

## Timing
- Grant is combinational from `req` in the same cycle, so arbitration adds zero latency.
- Read data arrives one cycle after grant: `rvalid` at cycle N+1 for a grant at cycle N.
- Simultaneous new requests in the first cycle after reset: requester 0 is granted.
- Lock with no competitor: the owner keeps winning indefinitely, and `lock_cnt` stays 0.
- Lock at MAX_LOCK with a competitor: the other requester is forced exactly once. Both counters then restart.
- Reset asserted mid-read:
  - The next cycle has `rvalid` = 0 on both ports and the pending return is discarded.
  - All outputs are 0 while `reset` = 1, including `gnt`.

## Test plan
- Reset, then `m0_req` and `m1_req` both held as reads to addresses 0x0010 and 0x0020:
  - Grants alternate m0, m1, m0, …
  - `m0_rvalid` and `m1_rvalid` alternate one cycle later, each with the correct `main_mem_dat`.
- `m1` writes 0xBEEF to 0x0100 alone:
  - Same cycle: `m1_gnt` = 1, `main_mem_write` = 1, address 0x0100, data 0xBEEF.
  - Next cycle: no rvalid on either port.
- MAX_LOCK = 3, with `m0` requesting and locked continuously and `m1` requesting from cycle 0:
  - m0 is granted 4 times in a row: the first grant plus 3 locked grants.
  - Then m1 is granted once, then m0 again.
- Back-to-back reads, m0 to 0x0001 then m1 to 0x0002 in consecutive cycles:
  - `m0_rvalid` at N+1 and `m1_rvalid` at N+2, each carrying its own data.
- Reset pulsed in the cycle after an m0 read grant: `m0_rvalid` stays 0 and all outputs are 0.
- Idle, with no requests for 5 cycles: both `gnt` = 0, `main_mem_write` = 0, all addresses 0, and `lock_cnt` stays 0.

Source files
------------

// File: rtl/main_mem_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and main memory.
// The arbiter connects through the slave modport; requesters and memory use the master modport.
interface main_mem_arbiter_if;
    localparam int unsigned DW = 16;

    // Requester 0 (core data port)
    logic          m0_req;
    logic          m0_we;
    logic [DW-1:0] m0_adr;
    logic [DW-1:0] m0_wdat;
    logic          m0_lock;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdat;

    // Requester 1 (DMA / loader)
    logic          m1_req;
    logic          m1_we;
    logic [DW-1:0] m1_adr;
    logic [DW-1:0] m1_wdat;
    logic          m1_lock;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdat;

    // Main memory side
    logic [DW-1:0] main_mem_read_adr;
    logic [DW-1:0] main_mem_dat;
    logic          main_mem_write;
    logic [DW-1:0] main_mem_write_adr;
    logic [DW-1:0] main_mem_write_dat;

    modport slave (
        input  m0_req, m0_we, m0_adr, m0_wdat, m0_lock,
        output m0_gnt, m0_rvalid, m0_rdat,
        input  m1_req, m1_we, m1_adr, m1_wdat, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdat,
        output main_mem_read_adr, main_mem_write, main_mem_write_adr, main_mem_write_dat,
        input  main_mem_dat
    );

    modport master (
        output m0_req, m0_we, m0_adr, m0_wdat, m0_lock,
        input  m0_gnt, m0_rvalid, m0_rdat,
        output m1_req, m1_we, m1_adr, m1_wdat, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdat,
        input  main_mem_read_adr, main_mem_write, main_mem_write_adr, main_mem_write_dat,
        output main_mem_dat
    );
endinterface

// File: rtl/main_mem_arbiter.sv
// Two-requester main-memory arbiter: one access per cycle, round-robin with a bounded
// burst lock, zero-latency grant and tagged one-cycle read-data return.
module main_mem_arbiter #(
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    main_mem_arbiter_if.slave     bus
);
    localparam int unsigned DW    = 16;
    localparam int unsigned CNT_W = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

    logic             last_q,     last_d;
    logic             lock_own_q, lock_own_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             rd_pend_q,  rd_pend_d;
    logic             rd_tag_q,   rd_tag_d;

    logic          req0;
    logic          req1;
    logic          gnt_any;
    logic          win;
    logic          other_req;
    logic          win_we;
    logic          win_lock;
    logic [DW-1:0] win_adr;
    logic [DW-1:0] win_wdat;

    // Winner selection; requests are masked during reset so nothing is issued.
    always_comb begin
        req0    = bus.m0_req & ~reset;
        req1    = bus.m1_req & ~reset;
        gnt_any = req0 | req1;
        win     = 1'b0;
        if (req0 && req1) begin
            win = (lock_own_q && (lock_cnt_q < LOCK_MAX)) ? last_q : ~last_q;
        end else begin
            win = req1;
        end
        other_req = win ? req0 : req1;
        win_we    = win ? bus.m1_we   : bus.m0_we;
        win_lock  = win ? bus.m1_lock : bus.m0_lock;
        win_adr   = win ? bus.m1_adr  : bus.m0_adr;
        win_wdat  = win ? bus.m1_wdat : bus.m0_wdat;
    end

    // Next-state: lock counter only advances while the owner re-wins against a competitor.
    always_comb begin
        last_d     = last_q;
        lock_own_d = 1'b0;
        lock_cnt_d = '0;
        rd_pend_d  = 1'b0;
        rd_tag_d   = rd_tag_q;
        if (gnt_any) begin
            last_d     = win;
            lock_own_d = win_lock;
            if ((win == last_q) && lock_own_q && other_req) begin
                lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? LOCK_MAX : lock_cnt_q + CNT_W'(1);
            end
            if (!win_we) begin
                rd_pend_d = 1'b1;
                rd_tag_d  = win;
            end
        end
    end

    // Issue and read-return outputs; every output collapses to 0 while reset is high.
    always_comb begin
        bus.m0_gnt             = gnt_any & ~win;
        bus.m1_gnt             = gnt_any & win;
        bus.main_mem_write     = gnt_any & win_we;
        bus.main_mem_read_adr  = gnt_any ? win_adr  : '0;
        bus.main_mem_write_adr = gnt_any ? win_adr  : '0;
        bus.main_mem_write_dat = gnt_any ? win_wdat : '0;
        bus.m0_rvalid          = rd_pend_q & ~rd_tag_q & ~reset;
        bus.m1_rvalid          = rd_pend_q &  rd_tag_q & ~reset;
        bus.m0_rdat            = (rd_pend_q & ~rd_tag_q & ~reset) ? bus.main_mem_dat : '0;
        bus.m1_rdat            = (rd_pend_q &  rd_tag_q & ~reset) ? bus.main_mem_dat : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q     <= 1'b1;
            lock_own_q <= 1'b0;
            lock_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_tag_q   <= 1'b0;
        end else begin
            last_q     <= last_d;
            lock_own_q <= lock_own_d;
            lock_cnt_q <= lock_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_tag_q   <= rd_tag_d;
        end
    end
endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter: per-cycle comparison against a behavioural
// arbitration/memory model plus literal expectations for the key scenarios.
module tb_main_mem_arbiter;
    localparam int unsigned MAXL = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    main_mem_arbiter_if bus ();

    main_mem_arbiter #(.MAX_LOCK(MAXL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory: unwritten words read back as address ^ 0x5A00.
    logic [15:0] mem [logic [15:0]];

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'h5A00;
    endfunction

    always @(posedge clk) begin
        logic [15:0] ra;
        ra = bus.main_mem_read_adr;
        bus.main_mem_dat <= mem.exists(ra) ? mem[ra] : init_val(ra);
        if (bus.main_mem_write) mem[bus.main_mem_write_adr] = bus.main_mem_write_dat;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the memory, how long a locked burst has run, and
    // which requester is owed read data next cycle, tracked with plain integers.
    int          m_last;
    bit          m_own;
    int          m_streak;
    bit          ret_v;
    int          ret_who;
    logic [15:0] ret_d;
    logic [15:0] shadow [logic [15:0]];

    initial begin
        bit          rq [2];
        bit          we [2];
        bit          lk [2];
        logic [15:0] ad [2];
        logic [15:0] wd [2];
        bit          g;
        int          w;
        logic [15:0] e_adr, e_wd;
        bit          e_we;
        m_last = 1; m_own = 0; m_streak = 0; ret_v = 0; ret_who = 0; ret_d = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            rq[0] = bus.m0_req; we[0] = bus.m0_we; lk[0] = bus.m0_lock;
            ad[0] = bus.m0_adr; wd[0] = bus.m0_wdat;
            rq[1] = bus.m1_req; we[1] = bus.m1_we; lk[1] = bus.m1_lock;
            ad[1] = bus.m1_adr; wd[1] = bus.m1_wdat;
            if (reset) begin
                g = 0; w = 0;
            end else begin
                g = rq[0] || rq[1];
                if (rq[0] && rq[1])
                    w = (m_own && m_streak < int'(MAXL)) ? m_last : 1 - m_last;
                else
                    w = rq[1] ? 1 : 0;
            end
            e_we  = g && we[w];
            e_adr = g ? ad[w] : 16'h0000;
            e_wd  = g ? wd[w] : 16'h0000;
            chk("m_m0_gnt",   16'(bus.m0_gnt),    16'(g && w == 0));
            chk("m_m1_gnt",   16'(bus.m1_gnt),    16'(g && w == 1));
            chk("m_write",    16'(bus.main_mem_write), 16'(e_we));
            chk("m_rd_adr",   bus.main_mem_read_adr,   e_adr);
            chk("m_wr_adr",   bus.main_mem_write_adr,  e_adr);
            chk("m_wr_dat",   bus.main_mem_write_dat,  e_wd);
            chk("m_m0_rvalid", 16'(bus.m0_rvalid), 16'(!reset && ret_v && ret_who == 0));
            chk("m_m1_rvalid", 16'(bus.m1_rvalid), 16'(!reset && ret_v && ret_who == 1));
            chk("m_m0_rdat",  bus.m0_rdat, (!reset && ret_v && ret_who == 0) ? ret_d : 16'h0000);
            chk("m_m1_rdat",  bus.m1_rdat, (!reset && ret_v && ret_who == 1) ? ret_d : 16'h0000);
            if (reset) begin
                m_last = 1; m_own = 0; m_streak = 0; ret_v = 0;
            end else begin
                ret_v   = g && !we[w];
                ret_who = w;
                if (ret_v) ret_d = shadow.exists(ad[w]) ? shadow[ad[w]] : init_val(ad[w]);
                if (e_we) shadow[ad[w]] = wd[w];
                if (g) begin
                    if (w == m_last && m_own && rq[1-w])
                        m_streak = (m_streak + 1 > int'(MAXL)) ? int'(MAXL) : m_streak + 1;
                    else
                        m_streak = 0;
                    m_last = w;
                    m_own  = lk[w];
                end else begin
                    m_own = 0; m_streak = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input bit rq, input bit we, input logic [15:0] ad,
                          input logic [15:0] wd, input bit lk);
        bus.m0_req = rq; bus.m0_we = we; bus.m0_adr = ad; bus.m0_wdat = wd; bus.m0_lock = lk;
    endtask

    task automatic set_m1(input bit rq, input bit we, input logic [15:0] ad,
                          input logic [15:0] wd, input bit lk);
        bus.m1_req = rq; bus.m1_we = we; bus.m1_adr = ad; bus.m1_wdat = wd; bus.m1_lock = lk;
    endtask

    task automatic idle();
        set_m0(0, 0, 16'h0000, 16'h0000, 0);
        set_m1(0, 0, 16'h0000, 16'h0000, 0);
    endtask

    initial begin
        int exp_w;
        idle();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_m0_gnt", 16'(bus.m0_gnt), 16'h0000);
        chk("rst_m1_rvalid", 16'(bus.m1_rvalid), 16'h0000);
        tick();
        // Requests during reset must not be granted.
        set_m0(1, 0, 16'h0010, 16'h0000, 0);
        set_m1(1, 0, 16'h0020, 16'h0000, 0);
        @(negedge clk);
        chk("rst_gated_m0_gnt", 16'(bus.m0_gnt), 16'h0000);
        chk("rst_gated_rd_adr", bus.main_mem_read_adr, 16'h0000);
        tick();
        reset = 1'b0;

        // Round-robin alternation with tagged read return.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_m0_gnt", 16'(bus.m0_gnt), 16'((i % 2) == 0));
            chk("rr_m1_gnt", 16'(bus.m1_gnt), 16'((i % 2) == 1));
            chk("rr_rd_adr", bus.main_mem_read_adr, ((i % 2) == 0) ? 16'h0010 : 16'h0020);
            if (i > 0) begin
                chk("rr_m0_rvalid", 16'(bus.m0_rvalid), 16'((i % 2) == 1));
                chk("rr_m1_rvalid", 16'(bus.m1_rvalid), 16'((i % 2) == 0));
                chk("rr_rdat", ((i % 2) == 1) ? bus.m0_rdat : bus.m1_rdat,
                    ((i % 2) == 1) ? 16'h5A10 : 16'h5A20);
            end
            tick();
        end
        idle();
        @(negedge clk);
        chk("rr_last_m1_rvalid", 16'(bus.m1_rvalid), 16'h0001);
        chk("rr_last_m1_rdat", bus.m1_rdat, 16'h5A20);
        tick();

        // Lone write by m1, then read it back through m0.
        set_m1(1, 1, 16'h0100, 16'hBEEF, 0);
        @(negedge clk);
        chk("wr_m1_gnt", 16'(bus.m1_gnt), 16'h0001);
        chk("wr_m0_gnt", 16'(bus.m0_gnt), 16'h0000);
        chk("wr_write", 16'(bus.main_mem_write), 16'h0001);
        chk("wr_adr", bus.main_mem_write_adr, 16'h0100);
        chk("wr_dat", bus.main_mem_write_dat, 16'hBEEF);
        tick();
        idle();
        @(negedge clk);
        chk("wr_no_rvalid0", 16'(bus.m0_rvalid), 16'h0000);
        chk("wr_no_rvalid1", 16'(bus.m1_rvalid), 16'h0000);
        tick();
        set_m0(1, 0, 16'h0100, 16'h0000, 0);
        @(negedge clk);
        chk("rb_m0_gnt", 16'(bus.m0_gnt), 16'h0001);
        tick();
        idle();
        @(negedge clk);
        chk("rb_m0_rdat", bus.m0_rdat, 16'hBEEF);
        tick();

        // Idle: nothing issued.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_gnt", 16'({bus.m0_gnt, bus.m1_gnt}), 16'h0000);
            chk("idle_write", 16'(bus.main_mem_write), 16'h0000);
            chk("idle_adr", bus.main_mem_read_adr | bus.main_mem_write_adr, 16'h0000);
            tick();
        end

        // Bounded lock: m0 four times, m1 once, repeating.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_m0(1, 0, 16'h0030, 16'h0000, 1);
        set_m1(1, 0, 16'h0040, 16'h0000, 0);
        for (int i = 0; i < 10; i++) begin
            exp_w = ((i % 5) == 4) ? 1 : 0;
            @(negedge clk);
            chk("lock_m0_gnt", 16'(bus.m0_gnt), 16'(exp_w == 0));
            chk("lock_m1_gnt", 16'(bus.m1_gnt), 16'(exp_w == 1));
            tick();
        end

        // Lock without a competitor never uses up the lock budget.
        set_m1(0, 0, 16'h0000, 16'h0000, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("solo_m0_gnt", 16'(bus.m0_gnt), 16'h0001);
            tick();
        end
        set_m1(1, 0, 16'h0040, 16'h0000, 0);
        for (int i = 0; i < 5; i++) begin
            exp_w = (i == 3) ? 1 : 0;
            @(negedge clk);
            chk("join_m0_gnt", 16'(bus.m0_gnt), 16'(exp_w == 0));
            chk("join_m1_gnt", 16'(bus.m1_gnt), 16'(exp_w == 1));
            tick();
        end
        idle();
        tick();

        // Back-to-back reads from different requesters.
        set_m0(1, 0, 16'h0001, 16'h0000, 0);
        @(negedge clk);
        chk("b2b_m0_gnt", 16'(bus.m0_gnt), 16'h0001);
        tick();
        set_m0(0, 0, 16'h0000, 16'h0000, 0);
        set_m1(1, 0, 16'h0002, 16'h0000, 0);
        @(negedge clk);
        chk("b2b_m1_gnt", 16'(bus.m1_gnt), 16'h0001);
        chk("b2b_m0_rvalid", 16'(bus.m0_rvalid), 16'h0001);
        chk("b2b_m0_rdat", bus.m0_rdat, 16'h5A01);
        chk("b2b_m1_rdat_idle", bus.m1_rdat, 16'h0000);
        tick();
        idle();
        @(negedge clk);
        chk("b2b_m1_rvalid", 16'(bus.m1_rvalid), 16'h0001);
        chk("b2b_m1_rdat", bus.m1_rdat, 16'h5A02);
        chk("b2b_m0_rvalid_off", 16'(bus.m0_rvalid), 16'h0000);
        tick();

        // Reset in the cycle after a read grant discards the return.
        set_m0(1, 0, 16'h0005, 16'h0000, 0);
        @(negedge clk);
        chk("rr_rst_m0_gnt", 16'(bus.m0_gnt), 16'h0001);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_m0_gnt", 16'(bus.m0_gnt), 16'h0000);
        chk("midrst_m0_rvalid", 16'(bus.m0_rvalid), 16'h0000);
        chk("midrst_m0_rdat", bus.m0_rdat, 16'h0000);
        chk("midrst_rd_adr", bus.main_mem_read_adr, 16'h0000);
        tick();
        reset = 1'b0;
        idle();
        @(negedge clk);
        chk("postrst_m0_rvalid", 16'(bus.m0_rvalid), 16'h0000);
        chk("postrst_m1_rvalid", 16'(bus.m1_rvalid), 16'h0000);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
